// File: rtl/line_clear_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : line_clear_engine_if
// Description : Bus between the game executioner and the line clear engine.
//               The executioner drives the lock pulse and the fixed board.
//               The engine returns the working board, status and totals.
// Revision    : 1.0 - initial release
// ============================================================================
interface line_clear_engine_if #(
  parameter int ROWS        = 20,
  parameter int COLS        = 10,
  parameter int SCORE_WIDTH = 20,
  parameter int LINES_WIDTH = 16
);
  localparam int CNT_W = $clog2(ROWS + 1);

  logic                   lock_valid;
  logic [ROWS*COLS-1:0]   board_in;
  logic [ROWS*COLS-1:0]   board_out;
  logic                   clearing_line;
  logic                   busy;
  logic                   done;
  logic [CNT_W-1:0]       clear_count;
  logic [LINES_WIDTH-1:0] lines_total;
  logic [SCORE_WIDTH-1:0] score;

  // Executioner side
  modport master (
    output lock_valid, board_in,
    input  board_out, clearing_line, busy, done, clear_count, lines_total, score
  );

  // Engine side
  modport slave (
    input  lock_valid, board_in,
    output board_out, clearing_line, busy, done, clear_count, lines_total, score
  );
endinterface
`default_nettype wire

// File: rtl/line_clear_engine.sv
`default_nettype none
// ============================================================================
// Module      : line_clear_engine
// Description : Captures the fixed board when a piece locks, removes full
//               rows one per cycle (lowest full row first), then reports the
//               number of rows removed and updates saturating line/score
//               totals. Optional macro LINE_CLEAR_FLASH_EN inserts a FLASH
//               phase that blinks the full rows before collapsing them.
// Revision    : 1.0 - initial release
// ============================================================================
module line_clear_engine #(
  parameter int ROWS        = 20,
  parameter int COLS        = 10,
  parameter int SCORE_WIDTH = 20,
  parameter int LINES_WIDTH = 16
`ifdef LINE_CLEAR_FLASH_EN
  ,
  parameter int FLASH_CYCLES = 4
`endif
) (
  input wire logic           game_clk,
  input wire logic           reset,
  line_clear_engine_if.slave bus
);

  localparam int N     = ROWS * COLS;
  localparam int CNT_W = $clog2(ROWS + 1);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SCAN     = 3'd1;
  localparam logic [2:0] ST_COLLAPSE = 3'd2;
  localparam logic [2:0] ST_DONE     = 3'd3;
`ifdef LINE_CLEAR_FLASH_EN
  localparam logic [2:0] ST_FLASH    = 3'd4;
  localparam int         FC_W        = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
`endif

  logic [2:0]             state_q, state_d;
  logic [N-1:0]           board_q, board_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       clear_count_q, clear_count_d;
  logic [LINES_WIDTH-1:0] lines_total_q, lines_total_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
`ifdef LINE_CLEAR_FLASH_EN
  logic [FC_W-1:0]        flash_cnt_q, flash_cnt_d;
  logic [N-1:0]           full_bits;
`endif

  logic [ROWS-1:0]          full_mask;
  logic [ROWS-1:0]          rest_mask;
  logic [ROW_W-1:0]         low_row;
  logic [N-1:0]             collapsed;
  logic [LINES_WIDTH:0]     lines_sum;
  logic [10:0]              points;
  logic [SCORE_WIDTH+11:0]  score_sum;

  // A row is full when every column bit of the registered board is set
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign full_mask[r] = &board_q[r*COLS +: COLS];
`ifdef LINE_CLEAR_FLASH_EN
    assign full_bits[r*COLS +: COLS] = {COLS{full_mask[r]}};
`endif
  end

  // Lowest full row on screen = highest set index of full_mask
  always_comb begin
    low_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (full_mask[r]) low_row = ROW_W'(r);
    end
  end

  // Full rows still pending after the current removal (those above low_row)
  assign rest_mask = full_mask & ~(ROWS'(1) << low_row);

  // Board after removing low_row: everything above it drops one row
  always_comb begin
    collapsed = board_q;
    for (int r = 0; r < ROWS; r++) begin
      if (r == 0) begin
        collapsed[0 +: COLS] = '0;
      end else if (r <= int'(low_row)) begin
        collapsed[r*COLS +: COLS] = board_q[(r-1)*COLS +: COLS];
      end
    end
  end

  // Scoring table and saturating accumulators
  always_comb begin
    case (count_q)
      CNT_W'(0): points = 11'd0;
      CNT_W'(1): points = 11'd40;
      CNT_W'(2): points = 11'd100;
      CNT_W'(3): points = 11'd300;
      default:   points = 11'd1200;
    endcase
    lines_sum = {1'b0, lines_total_q} + (LINES_WIDTH+1)'(count_q);
    score_sum = (SCORE_WIDTH+12)'(score_q) + (SCORE_WIDTH+12)'(points);
  end

  // State and datapath registers
  always_ff @(posedge game_clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      board_q       <= '0;
      count_q       <= '0;
      clear_count_q <= '0;
      lines_total_q <= '0;
      score_q       <= '0;
`ifdef LINE_CLEAR_FLASH_EN
      flash_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      board_q       <= board_d;
      count_q       <= count_d;
      clear_count_q <= clear_count_d;
      lines_total_q <= lines_total_d;
      score_q       <= score_d;
`ifdef LINE_CLEAR_FLASH_EN
      flash_cnt_q   <= flash_cnt_d;
`endif
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.lock_valid) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (full_mask == '0) begin
          state_d = ST_DONE;
        end else begin
`ifdef LINE_CLEAR_FLASH_EN
          state_d = ST_FLASH;
`else
          state_d = ST_COLLAPSE;
`endif
        end
      end
`ifdef LINE_CLEAR_FLASH_EN
      ST_FLASH: begin
        if (flash_cnt_q == FC_W'(FLASH_CYCLES - 1)) state_d = ST_COLLAPSE;
      end
`endif
      ST_COLLAPSE: begin
        if (rest_mask == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath updates per state: capture, collapse, and end-of-clear totals
  always_comb begin
    board_d       = board_q;
    count_d       = count_q;
    clear_count_d = clear_count_q;
    lines_total_d = lines_total_q;
    score_d       = score_q;
`ifdef LINE_CLEAR_FLASH_EN
    flash_cnt_d   = flash_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.lock_valid) begin
          board_d = bus.board_in;
          count_d = '0;
        end
      end
`ifdef LINE_CLEAR_FLASH_EN
      ST_SCAN:  flash_cnt_d = '0;
      ST_FLASH: flash_cnt_d = flash_cnt_q + FC_W'(1);
`endif
      ST_COLLAPSE: begin
        board_d = collapsed;
        count_d = count_q + CNT_W'(1);
      end
      ST_DONE: begin
        clear_count_d = count_q;
        lines_total_d = lines_sum[LINES_WIDTH] ? '1 : lines_sum[LINES_WIDTH-1:0];
        score_d       = (|score_sum[SCORE_WIDTH+11:SCORE_WIDTH]) ? '1
                                                                 : score_sum[SCORE_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  // Outputs decoded from state; flash blanks full rows on odd counts only
  always_comb begin
    bus.busy          = (state_q != ST_IDLE);
    bus.done          = (state_q == ST_DONE);
    bus.board_out     = board_q;
    bus.clear_count   = clear_count_q;
    bus.lines_total   = lines_total_q;
    bus.score         = score_q;
`ifdef LINE_CLEAR_FLASH_EN
    bus.clearing_line = (state_q == ST_COLLAPSE) || (state_q == ST_FLASH);
    if ((state_q == ST_FLASH) && flash_cnt_q[0]) bus.board_out = board_q & ~full_bits;
`else
    bus.clearing_line = (state_q == ST_COLLAPSE);
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_line_clear_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_clear_engine
// Description : Self-checking bench for line_clear_engine. A row-level model
//               (delete full rows, let the rest fall) predicts every output
//               each cycle; directed cases pin the model with literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_clear_engine;
  localparam int ROWS        = 20;
  localparam int COLS        = 10;
  localparam int SCORE_WIDTH = 14;
  localparam int LINES_WIDTH = 9;
  localparam int N           = ROWS * COLS;
`ifdef LINE_CLEAR_FLASH_EN
  localparam int FL = 4;
`else
  localparam int FL = 0;
`endif
  localparam longint LMAX = (longint'(1) << LINES_WIDTH) - 1;
  localparam longint SMAX = (longint'(1) << SCORE_WIDTH) - 1;

  logic game_clk = 1'b0;
  logic reset    = 1'b1;
  always #5 game_clk = ~game_clk;

  line_clear_engine_if #(.ROWS(ROWS), .COLS(COLS), .SCORE_WIDTH(SCORE_WIDTH),
                         .LINES_WIDTH(LINES_WIDTH)) bus ();

  line_clear_engine #(
    .ROWS(ROWS), .COLS(COLS), .SCORE_WIDTH(SCORE_WIDTH), .LINES_WIDTH(LINES_WIDTH)
`ifdef LINE_CLEAR_FLASH_EN
    , .FLASH_CYCLES(FL)
`endif
  ) dut (
    .game_clk(game_clk),
    .reset(reset),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_board(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (row level) ----------------
  function automatic bit row_full(input logic [N-1:0] b, input int s);
    return &b[s*COLS +: COLS];
  endfunction

  function automatic int count_full(input logic [N-1:0] b);
    int n = 0;
    for (int s = 0; s < ROWS; s++) if (row_full(b, s)) n++;
    return n;
  endfunction

  // Delete the j lowest full rows and let everything above fall to the bottom
  function automatic logic [N-1:0] gravity(input logic [N-1:0] b, input int j);
    logic [N-1:0] r;
    int dst, skipped;
    r = '0; dst = ROWS - 1; skipped = 0;
    for (int s = ROWS - 1; s >= 0; s--) begin
      if (row_full(b, s) && skipped < j) skipped++;
      else begin
        r[dst*COLS +: COLS] = b[s*COLS +: COLS];
        dst--;
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] flash_view(input logic [N-1:0] b);
    logic [N-1:0] r = b;
    for (int s = 0; s < ROWS; s++) if (row_full(b, s)) r[s*COLS +: COLS] = '0;
    return r;
  endfunction

  function automatic longint pts(input int k);
    if (k == 0) return 0;
    if (k == 1) return 40;
    if (k == 2) return 100;
    if (k == 3) return 300;
    return 1200;
  endfunction

  int           m_t = 0;   // cycles since capture; 0 means idle
  int           m_k = 0;
  logic [N-1:0] m_orig = '0;
  logic [N-1:0] m_board = '0;
  longint       m_cc = 0, m_lines = 0, m_score = 0;

  function automatic int m_len();
    return (m_k == 0) ? 2 : 2 + m_k + FL;
  endfunction

  function automatic logic [N-1:0] exp_board();
    int j;
    if (m_t == 0) return m_board;
    if (m_k > 0 && m_t >= 2 && m_t <= FL + 1 && ((m_t - 2) % 2) == 1) return flash_view(m_orig);
    j = (m_k == 0) ? 0 : m_t - 2 - FL;
    if (j < 0) j = 0;
    if (j > m_k) j = m_k;
    return gravity(m_orig, j);
  endfunction

  always @(posedge game_clk) begin
    if (reset) begin
      m_t = 0; m_board = '0; m_cc = 0; m_lines = 0; m_score = 0;
    end else if (m_t == 0) begin
      if (bus.lock_valid) begin
        m_orig = bus.board_in;
        m_k    = count_full(m_orig);
        m_t    = 1;
      end
    end else if (m_t == m_len()) begin
      m_cc    = m_k;
      m_lines = (m_lines + m_k > LMAX) ? LMAX : m_lines + m_k;
      m_score = (m_score + pts(m_k) > SMAX) ? SMAX : m_score + pts(m_k);
      m_board = gravity(m_orig, m_k);
      m_t     = 0;
    end else begin
      m_t++;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge game_clk) begin
    if (check_en) begin
      chk("busy", 64'(bus.busy), 64'(m_t != 0));
      chk("done", 64'(bus.done), 64'(m_t != 0 && m_t == m_len()));
      chk("clearing_line", 64'(bus.clearing_line), 64'(m_k > 0 && m_t >= 2 && m_t < m_len()));
      chk_board("board_out", bus.board_out, exp_board());
      chk("clear_count", 64'(bus.clear_count), 64'(m_cc));
      chk("lines_total", 64'(bus.lines_total), 64'(m_lines));
      chk("score", 64'(bus.score), 64'(m_score));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge game_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [N-1:0] set_row(input logic [N-1:0] b, input int r,
                                           input logic [COLS-1:0] v);
    logic [N-1:0] x = b;
    x[r*COLS +: COLS] = v;
    return x;
  endfunction

  function automatic logic [N-1:0] rand_board();
    logic [N-1:0] b = '0;
    for (int s = 0; s < ROWS; s++) begin
      int unsigned sel = $urandom_range(0, 9);
      if (sel < 4)      b[s*COLS +: COLS] = '1;
      else if (sel < 6) b[s*COLS +: COLS] = '0;
      else              b[s*COLS +: COLS] = COLS'($urandom);
    end
    return b;
  endfunction

  task automatic run_lock(input logic [N-1:0] b, output int done_cyc, output int cl_cyc);
    bus.board_in   = b;
    bus.lock_valid = 1'b1;
    tick();
    bus.lock_valid = 1'b0;
    done_cyc = 0;
    cl_cyc   = 0;
    for (int c = 1; c <= 60; c++) begin
      if (bus.clearing_line) cl_cyc++;
      if (bus.done) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    if (done_cyc == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end
    tick();
  endtask

  logic [N-1:0] b;
  int dc, cl, ndone;
  localparam logic [COLS-1:0] ONES = '1;

  initial begin
    bus.lock_valid = 1'b0;
    bus.board_in   = '0;
    reset          = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    check_en = 1'b1;

    // Reset state
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk_board("rst_board", bus.board_out, '0);
    chk("rst_score", 64'(bus.score), 64'd0);
    chk("rst_lines", 64'(bus.lines_total), 64'd0);

    // Empty board: done two cycles after the lock, nothing cleared
    run_lock('0, dc, cl);
    chk("empty_done_cyc", 64'(dc), 64'd2);
    chk("empty_clearing", 64'(cl), 64'd0);
    chk("empty_count", 64'(bus.clear_count), 64'd0);
    chk("empty_score", 64'(bus.score), 64'd0);

    // Single line with a block sitting on it
    do_reset();
    b = set_row(set_row('0, 19, ONES), 18, 10'b0000000001);
    run_lock(b, dc, cl);
    chk("one_clearing", 64'(cl), 64'(1 + FL));
    chk("one_done_cyc", 64'(dc), 64'(3 + FL));
    chk("one_row19", 64'(bus.board_out[19*COLS +: COLS]), 64'd1);
    chk("one_row18", 64'(bus.board_out[18*COLS +: COLS]), 64'd0);
    chk("one_count", 64'(bus.clear_count), 64'd1);
    chk("one_score", 64'(bus.score), 64'd40);
    chk("one_lines", 64'(bus.lines_total), 64'd1);

    // Tetris
    do_reset();
    b = set_row(set_row(set_row(set_row('0, 16, ONES), 17, ONES), 18, ONES), 19, ONES);
    run_lock(b, dc, cl);
    chk("tetris_clearing", 64'(cl), 64'(4 + FL));
    chk("tetris_done_cyc", 64'(dc), 64'(6 + FL));
    chk_board("tetris_board", bus.board_out, '0);
    chk("tetris_score", 64'(bus.score), 64'd1200);
    chk("tetris_lines", 64'(bus.lines_total), 64'd4);

    // Non-adjacent full rows, then a follow-up single
    do_reset();
    b = set_row(set_row(set_row('0, 19, ONES), 17, ONES), 18, 10'h155);
    run_lock(b, dc, cl);
    chk("split_clearing", 64'(cl), 64'(2 + FL));
    chk("split_row19", 64'(bus.board_out[19*COLS +: COLS]), 64'h155);
    chk("split_row18", 64'(bus.board_out[18*COLS +: COLS]), 64'd0);
    chk("split_score", 64'(bus.score), 64'd100);
    run_lock(set_row('0, 19, ONES), dc, cl);
    chk("split2_score", 64'(bus.score), 64'd140);
    chk("split2_lines", 64'(bus.lines_total), 64'd3);

    // Reset on the second collapse cycle of a 3-line clear
    do_reset();
    run_lock(set_row('0, 19, ONES), dc, cl);
    b = set_row(set_row(set_row(set_row('0, 17, ONES), 18, ONES), 19, ONES), 5, 10'h3);
    bus.board_in   = b;
    bus.lock_valid = 1'b1;
    tick();
    bus.lock_valid = 1'b0;
    repeat (FL + 2) tick();
    chk("midrst_in_collapse", 64'(bus.clearing_line), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk_board("midrst_board", bus.board_out, '0);
    chk("midrst_score", 64'(bus.score), 64'd0);
    chk("midrst_lines", 64'(bus.lines_total), 64'd0);
    chk("midrst_count", 64'(bus.clear_count), 64'd0);

    // lock_valid while busy and in the DONE cycle is ignored
    do_reset();
    b = set_row(set_row(set_row('0, 18, ONES), 19, ONES), 0, 10'h2AA);
    bus.board_in   = b;
    bus.lock_valid = 1'b1;
    tick();
    bus.board_in = '1;
    tick();
    bus.lock_valid = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done) begin
        ndone++;
        bus.lock_valid = 1'b1;
      end else begin
        bus.lock_valid = 1'b0;
      end
      tick();
    end
    bus.lock_valid = 1'b0;
    chk("busy_lock_ndone", 64'(ndone), 64'd1);
    chk_board("busy_lock_board", bus.board_out, set_row('0, 2, 10'h2AA));

    // Saturation of score and line totals with full-board clears
    do_reset();
    for (int i = 0; i < 30; i++) run_lock('1, dc, cl);
    chk("sat_count", 64'(bus.clear_count), 64'd20);
    chk("sat_score", 64'(bus.score), 64'(SMAX));
    chk("sat_lines", 64'(bus.lines_total), 64'(LMAX));

    // Random traffic, including locks while busy and occasional resets
    do_reset();
    for (int c = 0; c < 5000; c++) begin
      reset          = ($urandom_range(0, 299) == 0);
      bus.lock_valid = ($urandom_range(0, 3) == 0);
      bus.board_in   = rand_board();
      tick();
    end
    reset          = 1'b0;
    bus.lock_valid = 1'b0;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_clear_engine.md
Name: line_clear_engine

Overview:
Downstream of the game executioner. Captures the fixed board on the cycle a piece locks. Finds full rows and collapses them one row per game_clk cycle. Drives clearing_line back to the executioner while busy, and keeps line and score totals for the display and telemetry path.

Parameters:
ROWS, 20, board height; row 0 is the top, row ROWS-1 is the bottom
COLS, 10, board width; bit c of a row is column c
SCORE_WIDTH, 20, score accumulator width
LINES_WIDTH, 16, total-lines counter width
FLASH_CYCLES, 4, FLASH state dwell in cycles; used only with LINE_CLEAR_FLASH_EN

Ports:
game_clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high
lock_valid  in  1  one-cycle pulse: piece locked, board_in is valid this cycle
board_in  in  ROWS*COLS  fixed board; row r occupies bits [r*COLS +: COLS]
board_out  out  ROWS*COLS  working board register, same packing as board_in
clearing_line  out  1  high while state is FLASH or COLLAPSE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in DONE; board_out is final
clear_count  out  $clog2(ROWS+1)  rows removed by the last operation; held until next DONE
lines_total  out  LINES_WIDTH  saturating sum of all clear_count values
score  out  SCORE_WIDTH  saturating score

Behaviour:
- Reset (synchronous, active-high) from any state, including mid-COLLAPSE:
  - state goes to IDLE; board_reg is cleared.
  - clear_count, lines_total and score go to 0.
  - clearing_line, busy and done go low.
- full_mask[r] = AND of all bits in row r of board_reg. Combinational, from the register only.
- IDLE:
  - lock_valid=1 loads board_in into board_reg, clears the working count, and moves to SCAN next cycle.
  - lock_valid while busy=1 is ignored: no capture, no error.
- SCAN, one cycle:
  - full_mask==0 goes to DONE.
  - Otherwise goes to COLLAPSE, or to FLASH when LINE_CLEAR_FLASH_EN is defined.
- COLLAPSE, one cycle per removed row:
  - r = highest-index set bit of full_mask, i.e. the lowest full row.
  - Rows 1..r take the old contents of rows 0..r-1; row 0 becomes all zeros; the working count increments.
  - Repeat until full_mask==0, then go to DONE.
  - Removing k full rows therefore takes exactly k cycles. Non-adjacent full rows need no special handling.
- DONE, one cycle:
  - done=1; clear_count takes the working count.
  - lines_total += count, saturating at all-ones.
  - score += table[count]: 0→0, 1→40, 2→100, 3→300, ≥4→1200. Saturates at 2^SCORE_WIDTH-1.
  - Returns to IDLE.
- Latency from lock_valid to done: 2 + k cycles, plus FLASH_CYCLES when flash is enabled.
- board_out is always board_reg. It changes only on IDLE capture, during COLLAPSE, and on reset.
- lock_valid asserted in the DONE cycle is ignored; the next capture is possible from IDLE one cycle later.

Optional Feature:
LINE_CLEAR_FLASH_EN
- Defined: SCAN with full_mask≠0 enters FLASH for FLASH_CYCLES cycles, then COLLAPSE.
  - A cycle counter runs 0..FLASH_CYCLES-1.
  - On odd counter values, board_out shows the full rows as all zeros; other rows are unchanged and board_reg is not modified.
  - clearing_line is high throughout FLASH.
- Undefined: no FLASH state or counter exists; SCAN goes directly to COLLAPSE; FLASH_CYCLES is unused.

Test Plan:
- Reset, then lock_valid with an empty board → done pulses 2 cycles later; clear_count=0; score=0; clearing_line never rises.
- Row 19 full, row 18 = 10'b0000000001 → clearing_line high 1 cycle; afterwards row 19 = 10'b0000000001 and row 18 = 0; clear_count=1; score=40; lines_total=1.
- Rows 16-19 full (tetris) → clearing_line high exactly 4 cycles; rows 16-19 become 0; score=1200; done at cycle 6.
- Rows 19 and 17 full, row 18 = 10'h155 → 2 COLLAPSE cycles; final row 19 = 10'h155; score=100. Then a second lock with row 19 full → score=140, lines_total=3.
- Reset asserted on the 2nd COLLAPSE cycle of a 3-line clear → next cycle state is IDLE, board_out=0, counters=0. A lock_valid pulse during busy in a separate run produces no second done.
- With LINE_CLEAR_FLASH_EN and FLASH_CYCLES=4, one full row → clearing_line high 5 cycles; the full row reads 0 on flash counts 1 and 3; done at cycle 7.
